// File: rtl/sipo_deser_if.sv
// sipo_deser_if -- serial-in / parallel-out bus bundle for sipo_deser.
// Optional parity status output is present only with SIPO_DESER_PARITY_EN.
interface sipo_deser_if #(
  parameter int unsigned Width = 8
);
  logic             sd_i;
  logic             sv_i;
  logic             sof_i;
  logic             ready_i;
  logic [Width-1:0] q_o;
  logic             valid_o;
  logic             ovr_o;
  logic             busy_o;
`ifdef SIPO_DESER_PARITY_EN
  logic             perr_o;
`endif

  // Deserializer side: consumes the serial stream, produces the word.
  modport slave (
    input  sd_i,
    input  sv_i,
    input  sof_i,
    input  ready_i,
    output q_o,
    output valid_o,
    output ovr_o,
`ifdef SIPO_DESER_PARITY_EN
    output perr_o,
`endif
    output busy_o
  );

  // Environment side: drives the serial stream, consumes the word.
  modport master (
    output sd_i,
    output sv_i,
    output sof_i,
    output ready_i,
    input  q_o,
    input  valid_o,
    input  ovr_o,
`ifdef SIPO_DESER_PARITY_EN
    input  perr_o,
`endif
    input  busy_o
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser -- MSB-first serial-to-parallel deserializer with a one-word
// output register, valid/ready handshake and overrun pulse.
// Build option SIPO_DESER_PARITY_EN appends a trailing even-parity bit to
// each frame and adds perr_o to the bus.
module sipo_deser #(
  parameter int unsigned Width = 8
) (
  input logic        clk_i,
  input logic        rst_i,
  sipo_deser_if.slave bus
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int unsigned FrameLen = Width + 1;
`else
  localparam int unsigned FrameLen = Width;
`endif
  // Shift register keeps every frame bit except the one arriving now.
  localparam int unsigned SrW  = FrameLen - 1;
  localparam int unsigned CntW = $clog2(FrameLen);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  if (Width < 2 || Width > 32) begin : g_bad_width
    $error("sipo_deser: Width must be within 2..32");
  end

  logic [0:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q,   cnt_d;
  logic [SrW-1:0]      sr_q,    sr_d;
  logic [Width-1:0]    q_q,     q_d;
  logic                valid_q, valid_d;
  logic                ovr_q,   ovr_d;
`ifdef SIPO_DESER_PARITY_EN
  logic                perr_q,  perr_d;
`endif

  logic [FrameLen-1:0] frame_w;
  logic [Width-1:0]    word_w;
  logic                word_done;

  // Complete frame as it would look if the current bit were the last one.
  assign frame_w = {sr_q, bus.sd_i};
`ifdef SIPO_DESER_PARITY_EN
  assign word_w  = frame_w[FrameLen-1:1];
`else
  assign word_w  = frame_w;
`endif

  // Frame FSM: start on qualified sof, shift qualified bits, finish on count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_done = 1'b0;
    if (bus.sv_i) begin
      if (bus.sof_i) begin
        // sof always wins: starts from IDLE or aborts a partial word.
        state_d = SHIFT;
        cnt_d   = CntW'(1);
        sr_d    = SrW'(bus.sd_i);
      end else if (state_q == SHIFT) begin
        if (cnt_q == CntW'(FrameLen - 1)) begin
          word_done = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          sr_d      = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          sr_d  = frame_w[SrW-1:0];
        end
      end
    end
  end

  // Output register: consume on ready, load or flag overrun on completion.
  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    perr_d  = perr_q;
`endif
    if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
    if (word_done) begin
      if (!valid_q || bus.ready_i) begin
        q_d     = word_w;
        valid_d = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
        perr_d  = ^frame_w;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and output flops with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.q_o     = q_q;
  assign bus.valid_o = valid_q;
  assign bus.ovr_o   = ovr_q;
  assign bus.busy_o  = (state_q == SHIFT);
`ifdef SIPO_DESER_PARITY_EN
  assign bus.perr_o  = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser -- directed self-checking bench for sipo_deser (Width=8).
// Honours SIPO_DESER_PARITY_EN by appending a parity bit to each frame.
module tb_sipo_deser;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sipo_deser_if #(.Width(8)) bus ();

  sipo_deser #(.Width(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic sof);
    bus.sv_i  = 1'b1;
    bus.sd_i  = b;
    bus.sof_i = sof;
    @(posedge clk_i); #1;
    bus.sv_i  = 1'b0;
    bus.sof_i = 1'b0;
    bus.sd_i  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
  endtask

  // gap[i]=1 inserts an sv_i=0 cycle after data bit i (0-based);
  // rdy_last 0/1 sets ready_i for the final bit only, 2 leaves it alone.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] gap,
                            input logic par, input int rdy_last);
    logic [8:0] fb;
    int         n;
`ifdef SIPO_DESER_PARITY_EN
    fb = {d, par};
    n  = 9;
`else
    fb = {1'b0, d};
    n  = 8;
    if (par) fb[8] = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && rdy_last != 2) bus.ready_i = (rdy_last == 1);
      send_bit(fb[n-1-i], i == 0);
      if (i < 8 && gap[i]) idle_cycle();
    end
  endtask

  initial begin
    bus.sd_i    = 1'b0;
    bus.sv_i    = 1'b0;
    bus.sof_i   = 1'b0;
    bus.ready_i = 1'b1;

    // Reset values while held in reset
    #1;
    chk("rst_q",     32'(bus.q_o),     32'h00);
    chk("rst_valid", 32'(bus.valid_o), 32'h0);
    chk("rst_ovr",   32'(bus.ovr_o),   32'h0);
    chk("rst_busy",  32'(bus.busy_o),  32'h0);
    #11 rst_i = 1'b1;
    #1;
    chk("release_q",     32'(bus.q_o),     32'h00);
    chk("release_valid", 32'(bus.valid_o), 32'h0);
    idle_cycle();

    // IDLE ignores bits without sof, and sof without sv
    send_bit(1'b1, 1'b0);
    chk("idle_nosof_busy", 32'(bus.busy_o), 32'h0);
    bus.sof_i = 1'b1;
    idle_cycle();
    bus.sof_i = 1'b0;
    chk("idle_nosv_busy", 32'(bus.busy_o), 32'h0);

    // Basic frame A5 with ready high
    for (int i = 0; i < 7; i++) send_bit(((8'hA5 >> (7 - i)) & 1) != 0, i == 0);
    chk("basic_busy_mid",  32'(bus.busy_o),  32'h1);
    chk("basic_valid_mid", 32'(bus.valid_o), 32'h0);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
`else
    send_bit(1'b1, 1'b0);
`endif
    chk("basic_q",     32'(bus.q_o),     32'hA5);
    chk("basic_valid", 32'(bus.valid_o), 32'h1);
    chk("basic_busy",  32'(bus.busy_o),  32'h0);
    chk("basic_ovr",   32'(bus.ovr_o),   32'h0);
`ifdef SIPO_DESER_PARITY_EN
    chk("basic_perr",  32'(bus.perr_o),  32'h0);
`endif
    idle_cycle();
    chk("basic_consumed", 32'(bus.valid_o), 32'h0);
    chk("basic_q_hold",   32'(bus.q_o),     32'hA5);

    // Gaps after bits 3 and 6: state holds during sv_i=0
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle_cycle();
    chk("gap_busy_hold", 32'(bus.busy_o), 32'h1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle_cycle();
    send_bit(1'b0, 1'b0);
    chk("gap_valid_pre", 32'(bus.valid_o), 32'h0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("gap_q",     32'(bus.q_o),     32'hA5);
    chk("gap_valid", 32'(bus.valid_o), 32'h1);
    idle_cycle();

    // Restart: 1111 then a fresh sof frame 03
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    chk("restart_valid_partial", 32'(bus.valid_o), 32'h0);
    for (int i = 0; i < 7; i++) begin
      send_bit(i == 6, i == 0);
      chk("restart_no_early_valid", 32'(bus.valid_o), 32'h0);
    end
    send_bit(1'b1, 1'b0);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("restart_q",     32'(bus.q_o),     32'h03);
    chk("restart_valid", 32'(bus.valid_o), 32'h1);
    idle_cycle();
    chk("restart_single_word", 32'(bus.valid_o), 32'h0);

    // Overrun: 3C held, C3 dropped with one-cycle ovr pulse
    bus.ready_i = 1'b0;
    send_frame(8'h3C, 8'h00, 1'b0, 2);
    chk("ovr_first_q",     32'(bus.q_o),     32'h3C);
    chk("ovr_first_valid", 32'(bus.valid_o), 32'h1);
    send_frame(8'hC3, 8'h00, 1'b0, 2);
    chk("ovr_q_kept", 32'(bus.q_o),     32'h3C);
    chk("ovr_pulse",  32'(bus.ovr_o),   32'h1);
    chk("ovr_valid",  32'(bus.valid_o), 32'h1);
    idle_cycle();
    chk("ovr_pulse_end", 32'(bus.ovr_o), 32'h0);
    bus.ready_i = 1'b1;
    idle_cycle();
    chk("ovr_drain_valid", 32'(bus.valid_o), 32'h0);
    chk("ovr_drain_q",     32'(bus.q_o),     32'h3C);

    // Back-to-back: 11 pending, consumed on the edge completing 22
    bus.ready_i = 1'b0;
    send_frame(8'h11, 8'h00, 1'b0, 2);
    chk("b2b_first_q", 32'(bus.q_o), 32'h11);
    send_frame(8'h22, 8'h00, 1'b0, 1);
    chk("b2b_q",     32'(bus.q_o),     32'h22);
    chk("b2b_valid", 32'(bus.valid_o), 32'h1);
    chk("b2b_ovr",   32'(bus.ovr_o),   32'h0);
    idle_cycle();
    chk("b2b_drain", 32'(bus.valid_o), 32'h0);

    // Mid-frame reset after 5 bits, then FF frame
    for (int i = 0; i < 5; i++) send_bit(1'b0, i == 0);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_busy",  32'(bus.busy_o),  32'h0);
    chk("midrst_q",     32'(bus.q_o),     32'h00);
    chk("midrst_valid", 32'(bus.valid_o), 32'h0);
    #2 rst_i = 1'b1;
    idle_cycle();
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
    chk("postrst_needs_sof_busy",  32'(bus.busy_o),  32'h0);
    chk("postrst_needs_sof_valid", 32'(bus.valid_o), 32'h0);
    send_frame(8'hFF, 8'h00, 1'b1, 2);
    chk("postrst_q",     32'(bus.q_o),     32'hFF);
    chk("postrst_valid", 32'(bus.valid_o), 32'h1);
`ifdef SIPO_DESER_PARITY_EN
    chk("postrst_perr", 32'(bus.perr_o), 32'h1);
    idle_cycle();
    chk("perr_cleared", 32'(bus.perr_o), 32'h0);
`else
    idle_cycle();
`endif
    chk("final_valid", 32'(bus.valid_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL provide parameter: Width, default 8, data word width in bits (legal: 2..32).
REQ-002 SHALL provide port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port: sd_i  input  1  serial data bit, MSB first.
REQ-005 SHALL provide port: sv_i  input  1  serial bit valid; sd_i sampled only when high.
REQ-006 SHALL provide port: sof_i  input  1  start of frame, qualified by sv_i; marks current bit as first bit of a word.
REQ-007 SHALL provide port: ready_i  input  1  downstream accepts q_o when high together with valid_o.
REQ-008 SHALL provide port: q_o  output  Width  assembled parallel word, first received bit at q_o[Width-1].
REQ-009 SHALL provide port: valid_o  output  1  q_o holds an unconsumed word.
REQ-010 SHALL provide port: ovr_o  output  1  one-cycle pulse: completed word dropped because output full.
REQ-011 SHALL provide port: busy_o  output  1  high while FSM in SHIFT.

Function
REQ-012 SHALL implement FSM with states IDLE and SHIFT; a bit counter 0..FrameLen-1, where FrameLen = Width, or Width+1 when parity is compiled in.
REQ-013 In IDLE, SHALL ignore bits unless sv_i=1 and sof_i=1; such a bit is stored as bit 0 of the frame, counter set to 1, state SHIFT.
REQ-014 In SHIFT, each sv_i=1 cycle SHALL shift sd_i into LSB of the internal shift register and increment counter; sv_i=0 cycles hold all state.
REQ-015 In SHIFT, sv_i=1 with sof_i=1 SHALL abort the partial word (no output, no flag) and restart the frame with the current bit as bit 0.
REQ-016 On the edge sampling the final frame bit, SHALL return to IDLE; if valid_o=0 or ready_i=1 in that cycle, the word SHALL load into q_o and valid_o SHALL be 1 after that edge (latency: 0 cycles after the final-bit edge).
REQ-017 If final bit completes while valid_o=1 and ready_i=0, the new word SHALL be discarded, q_o unchanged, ovr_o=1 for exactly the following cycle.
REQ-018 valid_o SHALL fall on the edge where valid_o=1 and ready_i=1 unless a word completes on that same edge, in which case valid_o stays 1 and q_o takes the new word.
REQ-019 q_o SHALL change only on word load; ready_i without valid_o has no effect.
REQ-020 busy_o SHALL equal (state == SHIFT).
REQ-021 For Width=1-bit-per-frame corner: Width=2 SHALL complete after exactly 2 qualified bits; a single-bit frame with sof_i followed by sof_i SHALL restart, never emit.

Reset
REQ-022 When rst_i=0, SHALL asynchronously force state=IDLE, counter=0, shift register=0, q_o=0, valid_o=0, ovr_o=0, busy_o=0.
REQ-023 Reset mid-frame SHALL discard the partial word; first frame after release requires a new sof_i.
REQ-024 Release of rst_i SHALL take effect at the next rising clk_i; no output changes on release itself.

Configuration
REQ-025 Macro SIPO_DESER_PARITY_EN SHALL, when defined, extend each frame by one trailing even-parity bit (XOR of all Width data bits and parity bit = 0).
REQ-026 With SIPO_DESER_PARITY_EN defined, SHALL add output perr_o (1 bit): loaded alongside q_o, 1 if parity failed, cleared with valid_o; word still delivered.
REQ-027 Without SIPO_DESER_PARITY_EN, perr_o and parity logic SHALL not exist; FrameLen = Width.

Verification
REQ-028 Basic: Width=8, ready_i=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles with sof_i on first -> q_o=8'hA5, valid_o=1 after 8th edge, busy_o low.
REQ-029 Gaps: same frame with sv_i=0 inserted after bits 3 and 6 -> q_o=8'hA5, completion delayed by 2 cycles.
REQ-030 Restart: 4 bits 1111, then sof_i with bits 0,0,0,0,0,0,1,1 -> q_o=8'h03, only one valid word.
REQ-031 Overrun: ready_i=0, two frames 8'h3C then 8'hC3 -> q_o stays 8'h3C, ovr_o one-cycle pulse; ready_i=1 then clears valid_o.
REQ-032 Back-to-back: valid_o=1 with 8'h11, ready_i=1 on completion edge of 8'h22 -> valid_o stays 1, q_o=8'h22, no ovr_o.
REQ-033 Reset mid-frame after 5 bits, then release and 8'hFF frame -> q_o=8'hFF; with SIPO_DESER_PARITY_EN, 8'hFF + parity 1 -> perr_o=1.
